// File: rtl/mv_seq_pkg.sv
// Shared opcodes, FSM state encoding and status-word layout for the
// matrix-vector sequencer.
package mv_seq_pkg;

    localparam logic [3:0] OP_SET_ROWS  = 4'h1;
    localparam logic [3:0] OP_SET_COLS  = 4'h2;
    localparam logic [3:0] OP_START     = 4'h3;
    localparam logic [3:0] OP_WRITE_VEC = 4'h4;
    localparam logic [3:0] OP_WRITE_MAT = 4'h5;
    localparam logic [3:0] OP_READ_RES  = 4'h6;
    localparam logic [3:0] OP_STATUS    = 4'h7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_VEC,
        LOAD_MAT,
        CLEAR,
        FEED,
        DRAIN,
        READ,
        STAT
    } state_t;

    localparam int STAT_DONE_BIT = 15;
    localparam int STAT_ERR_BIT  = 14;
    localparam int STAT_BUSY_BIT = 13;
    localparam int STAT_COLS_LSB = 0;

endpackage

// File: rtl/mv_rsp_port.sv
// One-deep response holding register. Memory reads are presented the cycle
// after the address, then latched so the word stays stable under back-pressure.
module mv_rsp_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        st_req,
    input  logic [15:0] st_word,
    input  logic [15:0] mem_rdata,
    input  logic        rsp_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data
);

    logic        from_mem;
    logic [15:0] hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            from_mem  <= 1'b0;
            hold      <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                from_mem  <= 1'b0;
            end else if (from_mem) begin
                // freeze the read word; the address moves away after this cycle
                hold     <= mem_rdata;
                from_mem <= 1'b0;
            end
            if (rd_req) begin
                rsp_valid <= 1'b1;
                from_mem  <= 1'b1;
            end else if (st_req) begin
                rsp_valid <= 1'b1;
                hold      <= st_word;
            end
        end
    end

    assign rsp_data = from_mem ? mem_rdata : hold;

endmodule

// File: rtl/mv_seq_ctrl.sv
// Command sequencer for the matrix-vector systolic array: loads operands,
// runs feed/drain, writes results back and serves result/status readback.
//   state    | meaning
//   IDLE     | decode host commands
//   LOAD_VEC | write rows vector words from VEC_BASE
//   LOAD_MAT | write rows*cols matrix words, column-major, after the vector
//   CLEAR    | one-cycle accumulator clear
//   FEED     | rows+cols-1 skewed feed cycles
//   DRAIN    | cols drain pulses plus one trailing result write
//   READ     | stream cols results to host
//   STAT     | present status word until accepted
module mv_seq_ctrl
    import mv_seq_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter int                WORD_W    = 16,
    parameter int                PE_NUM    = 64,
    parameter logic [ADDR_W-1:0] VEC_BASE  = 10'h00F,
    parameter logic [ADDR_W-1:0] RES_BASE  = 10'h300,
    parameter logic [ADDR_W-1:0] ZERO_ADDR = 10'h3FF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              arr_clear,
    output logic              feed_valid,
    output logic [ADDR_W-1:0] vec_addr,
    output logic [ADDR_W-1:0] mat_base,
    output logic              drain,
    input  logic [WORD_W-1:0] arr_result,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [7:0]        rows, rows_nxt, cols, cols_nxt;
    logic              err, err_nxt, done, done_nxt;
    logic [15:0]       cnt, cnt_nxt;
    logic [7:0]        sub_r, sub_r_nxt, sub_c, sub_c_nxt;
    logic [ADDR_W-1:0] mat_acc, mat_acc_nxt;
    logic              ready_en;
    logic              rd_req, st_req;
    logic [15:0]       st_word;
    logic [3:0]        opcode;
    logic [7:0]        arg8;
    logic [15:0]       feed_last;
    logic              cmd_xfer, rsp_xfer;

    assign opcode    = cmd_data[15:12];
    assign arg8      = cmd_data[7:0];
    assign feed_last = 16'(rows) + 16'(cols) - 16'd2;
    assign cmd_xfer  = cmd_valid && ready_en;
    assign rsp_xfer  = rsp_valid && rsp_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        st_word                       = '0;
        st_word[STAT_DONE_BIT]        = done;
        st_word[STAT_ERR_BIT]         = err;
        st_word[STAT_BUSY_BIT]        = 1'b0;
        st_word[STAT_COLS_LSB +: 8]   = cols;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rows     <= 8'd1;
            cols     <= 8'd1;
            err      <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            sub_r    <= '0;
            sub_c    <= '0;
            mat_acc  <= ZERO_ADDR;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            rows     <= rows_nxt;
            cols     <= cols_nxt;
            err      <= err_nxt;
            done     <= done_nxt;
            cnt      <= cnt_nxt;
            sub_r    <= sub_r_nxt;
            sub_c    <= sub_c_nxt;
            mat_acc  <= mat_acc_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        rows_nxt    = rows;
        cols_nxt    = cols;
        err_nxt     = err;
        done_nxt    = done;
        cnt_nxt     = cnt;
        sub_r_nxt   = sub_r;
        sub_c_nxt   = sub_c;
        mat_acc_nxt = mat_acc;
        cmd_ready   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = '0;
        mem_raddr   = ZERO_ADDR;
        arr_clear   = 1'b0;
        feed_valid  = 1'b0;
        vec_addr    = ZERO_ADDR;
        mat_base    = ZERO_ADDR;
        drain       = 1'b0;
        rd_req      = 1'b0;
        st_req      = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready = ready_en;
                if (cmd_xfer) begin
                    cnt_nxt   = '0;
                    sub_r_nxt = '0;
                    sub_c_nxt = '0;
                    case (opcode)
                        OP_SET_ROWS: begin
                            if (arg8 == 8'd0 || int'(arg8) > PE_NUM) begin
                                err_nxt = 1'b1;
                            end else begin
                                rows_nxt = arg8;
                                done_nxt = 1'b0;
                            end
                        end
                        OP_SET_COLS: begin
                            if (arg8 == 8'd0 || int'(arg8) > PE_NUM) begin
                                err_nxt = 1'b1;
                            end else begin
                                cols_nxt = arg8;
                                done_nxt = 1'b0;
                            end
                        end
                        OP_START:     state_nxt = CLEAR;
                        OP_WRITE_VEC: state_nxt = LOAD_VEC;
                        OP_WRITE_MAT: state_nxt = LOAD_MAT;
                        OP_READ_RES: begin
                            if (done) state_nxt = READ;
                            else      err_nxt   = 1'b1;
                        end
                        OP_STATUS: begin
                            st_req    = 1'b1;
                            state_nxt = STAT;
                        end
                        default: err_nxt = 1'b1;
                    endcase
                end
            end
            LOAD_VEC: begin
                cmd_ready = ready_en;
                if (cmd_xfer) begin
                    mem_we    = 1'b1;
                    mem_waddr = VEC_BASE + cnt[ADDR_W-1:0];
                    mem_wdata = WORD_W'(cmd_data);
                    cnt_nxt   = cnt + 16'd1;
                    if (cnt == 16'(rows) - 16'd1) state_nxt = IDLE;
                end
            end
            LOAD_MAT: begin
                cmd_ready = ready_en;
                if (cmd_xfer) begin
                    mem_we    = 1'b1;
                    mem_waddr = VEC_BASE + ADDR_W'(rows) + cnt[ADDR_W-1:0];
                    mem_wdata = WORD_W'(cmd_data);
                    cnt_nxt   = cnt + 16'd1;
                    // row/col sub-counters find the end without forming rows*cols
                    if (sub_r == rows - 8'd1) begin
                        sub_r_nxt = '0;
                        sub_c_nxt = sub_c + 8'd1;
                        if (sub_c == cols - 8'd1) state_nxt = IDLE;
                    end else begin
                        sub_r_nxt = sub_r + 8'd1;
                    end
                end
            end
            CLEAR: begin
                arr_clear   = 1'b1;
                done_nxt    = 1'b0;
                cnt_nxt     = '0;
                mat_acc_nxt = VEC_BASE + ADDR_W'(rows);
                state_nxt   = FEED;
            end
            FEED: begin
                feed_valid  = 1'b1;
                if (cnt < 16'(rows)) vec_addr = VEC_BASE + cnt[ADDR_W-1:0];
                if (cnt < 16'(cols)) mat_base = mat_acc;
                mat_acc_nxt = mat_acc + ADDR_W'(rows);
                cnt_nxt     = cnt + 16'd1;
                if (cnt == feed_last) begin
                    cnt_nxt   = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // result j arrives one cycle after drain pulse j
                if (cnt < 16'(cols)) drain = 1'b1;
                if (cnt != 16'd0) begin
                    mem_we    = 1'b1;
                    mem_waddr = RES_BASE + ADDR_W'(cnt - 16'd1);
                    mem_wdata = arr_result;
                end
                cnt_nxt = cnt + 16'd1;
                if (cnt == 16'(cols)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            READ: begin
                if (!rsp_valid) begin
                    rd_req    = 1'b1;
                    mem_raddr = RES_BASE + cnt[ADDR_W-1:0];
                end
                if (rsp_xfer) begin
                    if (cnt == 16'(cols) - 16'd1) state_nxt = IDLE;
                    else                          cnt_nxt   = cnt + 16'd1;
                end
            end
            STAT: begin
                if (rsp_xfer) begin
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    mv_rsp_port u_rsp (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .st_req    (st_req),
        .st_word   (st_word),
        .mem_rdata (16'(mem_rdata)),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

endmodule

// File: tb/tb_mv_seq_ctrl.sv
// Scoreboard bench for mv_seq_ctrl: stimulus pushes expected writes, feed
// addresses and response words; a negedge monitor pops and compares them.
module tb_mv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic [9:0]  mem_raddr;
    logic [15:0] mem_rdata = '0;
    logic        arr_clear;
    logic        feed_valid;
    logic [9:0]  vec_addr;
    logic [9:0]  mat_base;
    logic        drain;
    logic [15:0] arr_result = '0;
    logic        busy;

    always #5 clk = ~clk;

    mv_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .arr_clear(arr_clear), .feed_valid(feed_valid),
        .vec_addr(vec_addr), .mat_base(mat_base),
        .drain(drain), .arr_result(arr_result), .busy(busy)
    );

    // scratchpad and a 3-row array model computing column dot products
    logic [15:0] mem [0:1023] = '{default: 16'h0};
    int          dcol = 0;

    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    always @(posedge clk) begin
        int acc;
        if (arr_clear) begin
            dcol <= 0;
        end else if (drain) begin
            acc = 0;
            for (int i = 0; i < 3; i++)
                acc += int'(mem[15 + i]) * int'(mem[18 + dcol * 3 + i]);
            arr_result <= acc[15:0];
            dcol       <= dcol + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int n_clear = 0;
    int n_drain = 0;
    int n_feed  = 0;

    logic [9:0]  exp_wa [$];
    logic [15:0] exp_wd [$];
    logic [9:0]  exp_fv [$];
    logic [9:0]  exp_fm [$];
    logic [15:0] exp_rsp [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (arr_clear) n_clear++;
            if (drain)     n_drain++;
            if (mem_we) begin
                if (exp_wa.size() == 0) miss("unexpected_write");
                else begin
                    chk("wr_addr", mem_waddr, exp_wa.pop_front());
                    chk("wr_data", mem_wdata, exp_wd.pop_front());
                end
            end
            if (feed_valid) begin
                n_feed++;
                if (exp_fv.size() == 0) miss("unexpected_feed");
                else begin
                    chk("vec_addr", vec_addr, exp_fv.pop_front());
                    chk("mat_base", mat_base, exp_fm.pop_front());
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) miss("unexpected_rsp");
                else chk("rsp_data", rsp_data, exp_rsp.pop_front());
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"},  cmd_ready,  0);
        chk({tag, "_rsp_valid"},  rsp_valid,  0);
        chk({tag, "_rsp_data"},   rsp_data,   0);
        chk({tag, "_mem_we"},     mem_we,     0);
        chk({tag, "_mem_waddr"},  mem_waddr,  0);
        chk({tag, "_mem_wdata"},  mem_wdata,  0);
        chk({tag, "_mem_raddr"},  mem_raddr,  10'h3FF);
        chk({tag, "_arr_clear"},  arr_clear,  0);
        chk({tag, "_feed_valid"}, feed_valid, 0);
        chk({tag, "_vec_addr"},   vec_addr,   10'h3FF);
        chk({tag, "_mat_base"},   mat_base,   10'h3FF);
        chk({tag, "_drain"},      drain,      0);
        chk({tag, "_busy"},       busy,       0);
    endtask

    task automatic send(input logic [15:0] w);
        int n = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) miss("send_timeout");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_rsp.size() != 0 || exp_wa.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy || exp_rsp.size() != 0 || exp_wa.size() != 0) miss({tag, "_idle_timeout"});
        @(posedge clk); #1;
    endtask

    task automatic stat(input logic [15:0] e, input string tag);
        exp_rsp.push_back(e);
        send(16'h7000);
        wait_idle(tag);
    endtask

    task automatic run_start(input string tag);
        int c0 = n_clear;
        int d0 = n_drain;
        int f0 = n_feed;
        exp_fv.push_back(10'h00F); exp_fm.push_back(10'h012);
        exp_fv.push_back(10'h010); exp_fm.push_back(10'h015);
        exp_fv.push_back(10'h011); exp_fm.push_back(10'h3FF);
        exp_fv.push_back(10'h3FF); exp_fm.push_back(10'h3FF);
        exp_wa.push_back(10'h300); exp_wd.push_back(16'd14);
        exp_wa.push_back(10'h301); exp_wd.push_back(16'd32);
        send(16'h3000);
        wait_idle(tag);
        chk({tag, "_clear_cycles"}, n_clear - c0, 1);
        chk({tag, "_feed_cycles"},  n_feed - f0,  4);
        chk({tag, "_drain_cycles"}, n_drain - d0, 2);
        chk({tag, "_feed_q_empty"}, exp_fv.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check_reset("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;

        stat(16'h0001, "stat_reset");
        send(16'h6000);                       // READ_RES before any run
        wait_idle("read_early");
        stat(16'h4001, "stat_err_read");
        stat(16'h0001, "stat_err_cleared");

        send(16'h1003);
        send(16'h2002);
        stat(16'h0002, "stat_dims");

        for (int k = 0; k < 3; k++) begin
            exp_wa.push_back(10'(10'h00F + k)); exp_wd.push_back(16'(k + 1));
        end
        send(16'h4000);
        send(16'd1);
        @(posedge clk); #1;                   // bubble inside the load
        send(16'd2);
        @(posedge clk); #1;
        send(16'd3);
        wait_idle("load_vec");

        for (int k = 0; k < 6; k++) begin
            exp_wa.push_back(10'(10'h012 + k)); exp_wd.push_back(16'(k + 1));
        end
        send(16'h5000);
        for (int k = 1; k <= 6; k++) send(16'(k));
        wait_idle("load_mat");

        run_start("run1");

        exp_rsp.push_back(16'd14);
        exp_rsp.push_back(16'd32);
        rsp_ready = 1'b0;
        send(16'h6000);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) miss("read_valid_timeout");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data",  rsp_data,  16'd14);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle("read_res");

        send(16'h1000);
        send(16'h2041);
        send(16'hA000);
        stat(16'hC002, "stat_bad_cmds");
        stat(16'h8002, "stat_after_clear");

        run_start("run2");                    // dims unchanged by rejected sets

        exp_fv.push_back(10'h00F); exp_fm.push_back(10'h012);
        exp_fv.push_back(10'h010); exp_fm.push_back(10'h015);
        exp_fv.push_back(10'h011); exp_fm.push_back(10'h3FF);
        send(16'h3000);
        n = 0;
        @(negedge clk);
        while (!feed_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!feed_valid) miss("feed_timeout");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("rst_feed");
        chk("rst_feed_q_empty", exp_fv.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stat(16'h0001, "stat_after_rst");

        chk("final_wr_q_empty",  exp_wa.size(),  0);
        chk("final_rsp_q_empty", exp_rsp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mv_seq_ctrl.md
Name: mv_seq_ctrl

Overview:
- Parametrised command sequencer for the matrix-vector systolic array.
- Accepts 16-bit command/data words from the SPI bridge over a valid/ready bus.
- Loads the vector and matrix into the scratchpad, runs the array feed and drain, writes results back to the scratchpad, and streams results or status to the host.
- Successor to the fixed-size array controller: adds real reset, full handshakes, bounds checking with error status, configurable memory map and a status readback.

Parameters:
- ADDR_W, 10, scratchpad address width.
- WORD_W, 16, data word width; cmd/rsp words are always 16 bits.
- PE_NUM, 64, number of PEs; maximum rows and cols.
- VEC_BASE, 10'h00F, vector base address; the matrix is stored column-major from VEC_BASE+rows.
- RES_BASE, 10'h300, result base address.
- ZERO_ADDR, 10'h3FF, address driven when the array is idle; that location holds 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host word valid
- cmd_ready  out  1  block accepts cmd_data this cycle
- cmd_data  in  16  [15:12] opcode, [11:0] argument, or raw data word in load phases
- rsp_valid  out  1  response word valid
- rsp_ready  in  1  host accepts rsp_data
- rsp_data  out  16  result or status word
- mem_we  out  1  scratchpad write enable
- mem_waddr  out  ADDR_W  write address
- mem_wdata  out  WORD_W  write data
- mem_raddr  out  ADDR_W  read address; read data returns 1 cycle later
- mem_rdata  in  WORD_W  read data
- arr_clear  out  1  clear PE accumulators
- feed_valid  out  1  feed addresses valid this cycle
- vec_addr  out  ADDR_W  vector element address for PE row input
- mat_base  out  ADDR_W  column base; PE i reads mat_base+i
- drain  out  1  array shifts one result out per cycle
- arr_result  in  WORD_W  drained result, valid the cycle after drain
- busy  out  1  state is not IDLE

Behaviour:
- Reset values:
  - All outputs 0, except vec_addr, mat_base and mem_raddr, which are ZERO_ADDR.
  - State IDLE; rows=1, cols=1; err=0, done=0.
- Opcodes:
  - 1 SET_ROWS (arg[7:0])
  - 2 SET_COLS (arg[7:0])
  - 3 START
  - 4 WRITE_VEC
  - 5 WRITE_MAT
  - 6 READ_RES
  - 7 STATUS
  - 0 and 8-F: set err and are otherwise ignored.
- A transfer occurs when cmd_valid&&cmd_ready, or when rsp_valid&&rsp_ready.
- SET_ROWS / SET_COLS: an argument of 0 or >PE_NUM sets err and leaves the value unchanged. Otherwise the value is taken and done clears.
- cmd_ready is 1 in IDLE, LOAD_VEC and LOAD_MAT, and 0 in every other state.
- States:
  - IDLE:
    - WRITE_VEC -> LOAD_VEC.
    - WRITE_MAT -> LOAD_MAT.
    - START -> CLEAR.
    - READ_RES -> READ, but only if done=1; otherwise err is set and the state stays IDLE.
    - STATUS -> STAT.
  - LOAD_VEC: each accepted word k is written to VEC_BASE+k with mem_we pulsed in the same cycle. After rows words, the state returns to IDLE.
  - LOAD_MAT: word k is written to VEC_BASE+rows+k. After rows*cols words, the state returns to IDLE. The word counter increments; no multiplier is used.
  - CLEAR: arr_clear=1 for one cycle, done cleared -> FEED.
  - FEED: lasts rows+cols-1 cycles, cycle t=0.. .
    - For t<rows: vec_addr=VEC_BASE+t; otherwise ZERO_ADDR.
    - For t<cols: mat_base=VEC_BASE+rows+t*rows, formed by accumulating rows each cycle; otherwise ZERO_ADDR.
    - feed_valid=1 throughout -> DRAIN.
  - DRAIN: drain=1 for cols cycles.
    - Result j is written to RES_BASE+j one cycle after its drain pulse, so the last write lands in the cycle after DRAIN.
    - After the last write, done=1 -> IDLE.
  - READ: streams cols words from RES_BASE+j.
    - Drive mem_raddr, then present rsp_valid with the data one cycle later.
    - Hold rsp_data/rsp_valid until rsp_ready; the next address is issued only after the transfer.
    - Maximum throughput is one word per 2 cycles.
    - After the last transfer -> IDLE.
  - STAT: rsp_data={done, err, busy_sticky=0, 5'b0, cols[7:0]}. rsp_valid is held until transfer, then err is cleared -> IDLE.
- Widths:
  - rows and cols are 8-bit; the LOAD_MAT counter is 16-bit.
  - Address arithmetic wraps modulo 2^ADDR_W.
- Boundary conditions:
  - rows=cols=1: FEED lasts 1 cycle, DRAIN 1 cycle.
  - A 1-cycle bubble on cmd_valid inside a load phase is legal; the counter holds.
- rst_n is asserted mid-operation: immediate return to the reset values. Scratchpad contents are not touched; done=0.

Decomposition:
- Package mv_seq_pkg holds:
  - opcode localparams;
  - the state enum (IDLE, LOAD_VEC, LOAD_MAT, CLEAR, FEED, DRAIN, READ, STAT);
  - the status bit positions.
- One natural sub-module, mv_rsp_port: a 1-deep response holding register with a mem_raddr/mem_rdata 1-cycle alignment, shared by READ and STAT.

Test Plan:
- Reset in IDLE:
  - Check that all outputs match the reset values.
  - STATUS -> rsp_data=16'h0001 (cols=1).
- SET_ROWS 3, SET_COLS 2, WRITE_VEC with 1,2,3:
  - mem writes at 0x00F/0x010/0x011.
  - WRITE_MAT with 6 words -> writes at 0x012..0x017.
- START with rows=3, cols=2:
  - arr_clear for 1 cycle, then 4 FEED cycles.
  - vec_addr 0x00F,0x010,0x011,ZERO.
  - mat_base 0x012,0x015,ZERO,ZERO.
  - Then 2 drain cycles; results written at 0x300/0x301; done=1.
- READ_RES after that run with an array model producing 14,32:
  - rsp_data 14 then 32.
  - With rsp_ready held low for 5 cycles, rsp_valid and rsp_data are held stable.
- Error handling:
  - SET_ROWS 0, SET_COLS 65 and opcode 0xA each set err; the values stay unchanged.
  - READ_RES before any START also sets err.
  - STATUS returns bit14=1 and clears it.
- Reset during FEED:
  - Assert rst_n low at FEED cycle 2 -> all outputs return to their reset values immediately.
  - A subsequent STATUS shows done=0.
